// File: rtl/alu_dispatcher.sv
// alu_dispatcher: queues ALU commands, issues them one at a time to a lane of a
// vector ALU and returns each registered lane result as a tagged response.
//
// Optional feature: define ALU_DISPATCHER_ERR_FLAG_EN to add the rsp_err output
// (divide by zero or undefined opcode flagged alongside the response).
//
// Ports:
//   clk, arst            clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake into the DEPTH-entry FIFO
//   cmd_lane/sel/a/b/tag command fields
//   alu_a/b/sel[N]       per-lane operands/opcode, zero except the issuing lane
//   alu_enable[N]        one-hot for the single ISSUE cycle
//   alu_z[N]             registered lane results from the vector ALU
//   rsp_valid/rsp_ready  response handshake
//   rsp_data/tag/lane    captured result, held stable while rsp_valid is high
//   rsp_err              (optional) error flag travelling with the response
module alu_dispatcher #(
    parameter  int N     = 4,
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    parameter  int TAGW  = 4,
    localparam int LW    = $clog2(N),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [LW-1:0]        cmd_lane,
    input  logic [2:0]           cmd_sel,
    input  logic [WIDTH-1:0]     cmd_a,
    input  logic [WIDTH-1:0]     cmd_b,
    input  logic [TAGW-1:0]      cmd_tag,
    output logic [WIDTH-1:0]     alu_a [N],
    output logic [WIDTH-1:0]     alu_b [N],
    output logic [2:0]           alu_sel [N],
    output logic [N-1:0]         alu_enable,
    input  logic [2*WIDTH-1:0]   alu_z [N],
`ifdef ALU_DISPATCHER_ERR_FLAG_EN
    output logic                 rsp_err,
`endif
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_data,
    output logic [TAGW-1:0]      rsp_tag,
    output logic [LW-1:0]        rsp_lane
);
    typedef struct packed {
        logic [LW-1:0]    lane;
        logic [2:0]       sel;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAGW-1:0]  tag;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    cmd_t               fifo_q [DEPTH];
    cmd_t               iss_q;
    logic [PW-1:0]      wptr_q, rptr_q;
    logic [PW:0]        count_q;
    logic [2*WIDTH-1:0] rsp_data_q;
    logic [TAGW-1:0]    rsp_tag_q;
    logic [LW-1:0]      rsp_lane_q;
    logic               push, pop, not_empty;

    assign cmd_ready = count_q < (PW+1)'(DEPTH);
    assign not_empty = count_q != '0;
    assign push      = cmd_valid && cmd_ready;
    // The head is popped on the edge that enters ISSUE, from IDLE or from a
    // completed response handshake.
    assign pop       = not_empty && (state_q == IDLE || (state_q == RESP && rsp_ready));

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= '{cmd_lane, cmd_sel, cmd_a, cmd_b, cmd_tag};
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            iss_q   <= '0;
        end else begin
            wptr_q  <= wptr_q + PW'(push);
            rptr_q  <= rptr_q + PW'(pop);
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
            if (pop) iss_q <= fifo_q[rptr_q];
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = not_empty ? ISSUE : IDLE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = RESP;
            RESP:    state_d = rsp_ready ? (not_empty ? ISSUE : IDLE) : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_enable = '0;
        for (int i = 0; i < N; i++) begin
            alu_a[i]   = '0;
            alu_b[i]   = '0;
            alu_sel[i] = '0;
            if (state_q == ISSUE && iss_q.lane == LW'(i)) begin
                alu_a[i]      = iss_q.a;
                alu_b[i]      = iss_q.b;
                alu_sel[i]    = iss_q.sel;
                alu_enable[i] = 1'b1;
            end
        end
    end

    // The lane result is registered by the ALU at the end of ISSUE, so it is
    // valid throughout WAIT and is captured on the edge leaving WAIT.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
            rsp_lane_q <= '0;
        end else if (state_q == WAIT) begin
            rsp_data_q <= alu_z[iss_q.lane];
            rsp_tag_q  <= iss_q.tag;
            rsp_lane_q <= iss_q.lane;
        end
    end

`ifdef ALU_DISPATCHER_ERR_FLAG_EN
    logic rsp_err_q;
    always_ff @(posedge clk or posedge arst) begin
        if (arst)                rsp_err_q <= 1'b0;
        else if (state_q == WAIT) rsp_err_q <= (iss_q.sel == 3'b101 && iss_q.b == '0) || iss_q.sel[2:1] == 2'b11;
    end
    assign rsp_err = rsp_err_q;
`endif

    assign rsp_valid = state_q == RESP;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_lane  = rsp_lane_q;
endmodule
